pwm_capture: RTL and testbench

- Receive-side counterpart of the LED PWM generator: samples an external pulse train and measures its period, high time and 8-bit duty.
- Duty uses the same 0..255 scale the generator uses for its pulse compare.
- Used for loopback self-test of the RGB PWM outputs and for reading PWM from a header pin.
- Sits in the clki domain beside the RGB driver logic; results go to status registers or a debug LED path.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_duty_div.sv | 75 +++++++
 rtl/pwm_capture.sv | 167 ++++++++++++++++
 tb/tb_pwm_capture.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM capture block and its duty divider.
package pwm_pkg;

    localparam int CNT_W_DEFAULT   = 20;
    localparam int TIMEOUT_DEFAULT = 600000;
    localparam int DUTY_W          = 8;
    localparam int DIV_CYCLES      = 8;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        STUCK
    } state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider producing floor(num*256/den), one quotient bit per cycle.
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic              clki,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quo
);

    localparam logic [3:0] ITER_LAST = 4'(DIV_CYCLES - 1);
    localparam logic [3:0] ITER_END  = 4'(DIV_CYCLES);

    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  den_r;
    logic [DUTY_W-1:0] q;
    logic [3:0]        iter;
    logic [CNT_W:0]    shifted;
    logic              take;
    logic [CNT_W-1:0]  rem_next;
    logic [DUTY_W-1:0] q_next;

    // num < den always, so the remainder stays below den and fits in CNT_W bits
    always_comb begin
        shifted  = {rem, 1'b0};
        take     = (shifted >= {1'b0, den_r});
        rem_next = take ? (shifted[CNT_W-1:0] - den_r) : shifted[CNT_W-1:0];
        q_next   = {q[DUTY_W-2:0], take};
    end

    // busy spans the load cycle through the done cycle so a back-to-back start is refused
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            iter  <= '0;
            rem   <= '0;
            den_r <= '0;
            q     <= '0;
            quo   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
                iter <= '0;
            end else if (busy) begin
                if (iter == ITER_END) begin
                    busy <= 1'b0;
                end else begin
                    rem  <= rem_next;
                    q    <= q_next;
                    iter <= iter + 4'd1;
                    if (iter == ITER_LAST) begin
                        done <= 1'b1;
                        quo  <= q_next;
                    end
                end
            end else if (start) begin
                rem   <= num;
                den_r <= den;
                q     <= '0;
                iter  <= '0;
                busy  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and 8-bit duty of an asynchronous PWM input,
// flagging a stuck input and measurements lost while the divider is busy.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int TIMEOUT     = TIMEOUT_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clki,
    input  logic              rst_n,
    input  logic              pwm_in,
    input  logic              enable,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              stuck,
    output logic              stuck_level,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t              state, next_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                s, s_d, rise, fall;
    logic [CNT_W-1:0]    cnt, idle_cnt, hi_lat;
    logic [CNT_W-1:0]    pend_period, pend_high;
    logic                timeout, handoff, to_stuck, leave_stuck;
    logic                div_busy, div_done;
    logic [DUTY_W-1:0]   div_quo;

    assign s           = sync_q[SYNC_STAGES-1];
    assign rise        = s & ~s_d;
    assign fall        = ~s & s_d;
    assign timeout     = (idle_cnt == TMO);
    assign leave_stuck = (state == STUCK) && (next_state != STUCK);

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d    <= s;
        end
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Edges take priority over the timeout, so a rise in LOW is always a measurement
    always_comb begin
        next_state = state;
        handoff    = 1'b0;
        to_stuck   = 1'b0;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: if (rise) next_state = HIGH;
                HIGH: begin
                    if (fall) begin
                        next_state = LOW;
                    end else if (timeout) begin
                        next_state = STUCK;
                        to_stuck   = 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        next_state = HIGH;
                        handoff    = 1'b1;
                    end else if (timeout) begin
                        next_state = STUCK;
                        to_stuck   = 1'b1;
                    end
                end
                STUCK: begin
                    if (rise)      next_state = HIGH;
                    else if (fall) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idle_cnt <= '0;
            hi_lat   <= '0;
        end else if (!enable) begin
            cnt      <= '0;
            idle_cnt <= '0;
        end else begin
            cnt      <= rise ? CNT_W'(1) : ((cnt == TMO) ? cnt : cnt + 1'b1);
            idle_cnt <= (rise | fall) ? CNT_W'(1) : (timeout ? idle_cnt : idle_cnt + 1'b1);
            if (state == HIGH && fall) hi_lat <= cnt;
        end
    end

    pwm_duty_div #(.CNT_W(CNT_W)) u_div (
        .clki  (clki),
        .rst_n (rst_n),
        .start (handoff),
        .abort (~enable),
        .num   (hi_lat),
        .den   (cnt),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_quo)
    );

    // A stuck entry overrides duty after any coincident divider result
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            period      <= '0;
            high_time   <= '0;
            duty        <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
            overrun     <= 1'b0;
            pend_period <= '0;
            pend_high   <= '0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                stuck       <= 1'b0;
                stuck_level <= 1'b0;
                overrun     <= 1'b0;
            end else begin
                if (handoff) begin
                    if (div_busy) begin
                        overrun <= 1'b1;
                    end else begin
                        pend_period <= cnt;
                        pend_high   <= hi_lat;
                    end
                end
                if (div_done) begin
                    period    <= pend_period;
                    high_time <= pend_high;
                    duty      <= div_quo;
                    valid     <= 1'b1;
                end
                if (to_stuck) begin
                    stuck       <= 1'b1;
                    stuck_level <= s;
                    duty        <= {DUTY_W{s}};
                    valid       <= 1'b1;
                end else if (leave_stuck) begin
                    stuck       <= 1'b0;
                    stuck_level <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven pulse trains scored against
// a queue of expected valid strobes, plus hand-written stuck/abort/reset sequences.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int CNT_W       = 20;
    localparam int TIMEOUT     = 2000;
    localparam int SYNC_STAGES = 2;

    typedef struct {
        int p;
        int h;
        int n;
        int stride;
        int exp_duty;
        int exp_ovr;
    } vec_t;

    typedef struct {
        int period;
        int high;
        int duty;
        int stk;
        int stk_lvl;
        int due_lo;
        int due_hi;
    } exp_t;

    logic              clki;
    logic              rst_n;
    logic              pwm_in;
    logic              enable;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  high_time;
    logic [DUTY_W-1:0] duty;
    logic              valid;
    logic              stuck;
    logic              stuck_level;
    logic              overrun;

    int   checks;
    int   errors;
    int   cyc;
    exp_t exp_q[$];
    vec_t vecs[7];

    pwm_capture #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clki        (clki),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .enable      (enable),
        .period      (period),
        .high_time   (high_time),
        .duty        (duty),
        .valid       (valid),
        .stuck       (stuck),
        .stuck_level (stuck_level),
        .overrun     (overrun)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    initial cyc = 0;
    always @(posedge clki) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    // Each rise after the first closes a full period; stride 2 models every other handoff being dropped
    task automatic apply_stimulus(input int p, input int h, input int n, input int stride, input int d);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            if (i > 0 && ((i - 1) % stride) == 0)
                exp_q.push_back('{p, h, d, 0, 0, cyc + 12, cyc + 12});
            repeat (h) tick();
            pwm_in = 1'b0;
            repeat (p - h) tick();
        end
    endtask

    task automatic enable_cycle();
        enable = 1'b0;
        tick();
        check_output("disable_state_idle", longint'(dut.state), longint'(IDLE));
        tick();
        check_output("disable_overrun", overrun, 0);
        check_output("disable_stuck", stuck, 0);
        enable = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_period"}, period, 0);
        check_output({tag, "_high_time"}, high_time, 0);
        check_output({tag, "_duty"}, duty, 0);
        check_output({tag, "_valid"}, valid, 0);
        check_output({tag, "_stuck"}, stuck, 0);
        check_output({tag, "_stuck_level"}, stuck_level, 0);
        check_output({tag, "_overrun"}, overrun, 0);
    endtask

    // Every valid strobe must match the oldest expected result, in value and in cycle
    always @(negedge clki) begin
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got valid at cycle %0d expected none (period %0d duty %0d)",
                         cyc, period, duty);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("valid_period", period, e.period);
                check_output("valid_high_time", high_time, e.high);
                check_output("valid_duty", duty, e.duty);
                check_output("valid_stuck", stuck, e.stk);
                check_output("valid_stuck_level", stuck_level, e.stk_lvl);
                checks++;
                if (cyc < e.due_lo || cyc > e.due_hi) begin
                    errors++;
                    $display("[TB] FAIL valid_cycle: got cycle %0d expected %0d..%0d", cyc, e.due_lo, e.due_hi);
                end
            end
        end
    end

    initial begin
        int c;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        pwm_in = 1'b0;

        vecs[0] = '{256,  64,  4, 1,  64, 0};
        vecs[1] = '{300, 100,  3, 1,  85, 0};
        vecs[2] = '{256, 255,  3, 1, 255, 0};
        vecs[3] = '{1000,  1,  2, 1,   0, 0};
        vecs[4] = '{10,    5,  4, 1, 128, 0};
        vecs[5] = '{9,     4,  5, 2, 113, 1};
        vecs[6] = '{6,     3,  5, 2, 128, 1};

        repeat (3) tick();
        check_all_zero("reset");

        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        repeat (TIMEOUT + SYNC_STAGES + 2 + 5) tick();
        check_output("idle_no_timeout_stuck", stuck, 0);
        check_output("idle_no_timeout_state", longint'(dut.state), longint'(IDLE));

        for (int i = 0; i < 7; i++) begin
            enable_cycle();
            apply_stimulus(vecs[i].p, vecs[i].h, vecs[i].n, vecs[i].stride, vecs[i].exp_duty);
            repeat (20) tick();
            check_output($sformatf("vec%0d_queue_drained", i), exp_q.size(), 0);
            check_output($sformatf("vec%0d_overrun", i), overrun, vecs[i].exp_ovr);
        end

        // Stuck high after a good measurement, then recovery
        enable_cycle();
        apply_stimulus(256, 128, 2, 1, 128);
        pwm_in = 1'b1;
        c = cyc;
        exp_q.push_back('{256, 128, 128, 0, 0, c + 12, c + 12});
        exp_q.push_back('{256, 128, 255, 1, 1, c + TIMEOUT, c + TIMEOUT + 4});
        repeat (TIMEOUT + 10) tick();
        check_output("stuck_set", stuck, 1);
        check_output("stuck_level_set", stuck_level, 1);
        check_output("stuck_duty", duty, 255);
        pwm_in = 1'b0;
        repeat (5) tick();
        check_output("stuck_cleared", stuck, 0);
        check_output("stuck_exit_state", longint'(dut.state), longint'(IDLE));
        apply_stimulus(256, 128, 3, 1, 128);
        repeat (20) tick();
        check_output("stuck_recover_drained", exp_q.size(), 0);

        // Disable while the divider is mid-operation
        enable_cycle();
        pwm_in = 1'b1;
        repeat (100) tick();
        pwm_in = 1'b0;
        repeat (100) tick();
        pwm_in = 1'b1;
        repeat (6) tick();
        enable = 1'b0;
        tick();
        check_output("abort_state_idle", longint'(dut.state), longint'(IDLE));
        tick();
        check_output("abort_overrun", overrun, 0);
        enable = 1'b1;
        repeat (15) tick();
        pwm_in = 1'b0;
        repeat (50) tick();
        apply_stimulus(200, 50, 3, 1, 64);
        repeat (20) tick();
        check_output("abort_recover_drained", exp_q.size(), 0);

        // Reset asserted with a divide in flight
        enable_cycle();
        pwm_in = 1'b1;
        repeat (100) tick();
        pwm_in = 1'b0;
        repeat (50) tick();
        pwm_in = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check_all_zero("midreset");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check_output("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
